// File: rtl/rv32_wb_pkg.sv
// Shared types and constants for the integer register-file writeback path.
package rv32_wb_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lsu_fifo.sv
// Small FIFO holding formatted load results until they win the commit slot.
module wb_lsu_fifo
    import rv32_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     din,
    input  logic          pop,
    output wb_entry_t     dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/rv32_writeback_unit.sv
// Register-file writer: formats loads, arbitrates ALU vs. LSU commits and
// tracks pending destinations for decode hazard checks.
module rv32_writeback_unit #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int LSU_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [2:0]      lsu_funct3,
    input  logic [1:0]      lsu_addr_lo,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            RegWrite,
    output logic [4:0]      WriteRegister,
    output logic [XLEN-1:0] WriteData,
    output logic [31:0]     commit_count
);

    localparam int CW = $clog2(LSU_DEPTH) + 1;

    rv32_wb_pkg::wb_entry_t lsu_entry;
    rv32_wb_pkg::wb_entry_t lsu_head;
    rv32_wb_pkg::wb_entry_t commit;

    logic [XLEN-1:0]  lsu_fmt;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [CW-1:0]    lsu_count;
    logic             lsu_full;
    logic             lsu_empty;
    logic             drain_force;
    logic             alu_fire;
    logic             lsu_pop;
    logic             commit_valid;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    always_comb begin
        byte_sel = lsu_data[{lsu_addr_lo, 3'b000} +: 8];
        half_sel = lsu_addr_lo[1] ? lsu_data[31:16] : lsu_data[15:0];
        lsu_fmt  = '0;
        case (lsu_funct3)
            rv32_wb_pkg::F3_LB:  lsu_fmt = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            rv32_wb_pkg::F3_LH:  lsu_fmt = {{(XLEN-16){half_sel[15]}}, half_sel};
            rv32_wb_pkg::F3_LW:  lsu_fmt = lsu_data;
            rv32_wb_pkg::F3_LBU: lsu_fmt = {{(XLEN-8){1'b0}}, byte_sel};
            rv32_wb_pkg::F3_LHU: lsu_fmt = {{(XLEN-16){1'b0}}, half_sel};
            default:             lsu_fmt = '0;
        endcase
    end

    assign lsu_entry = '{rd: lsu_rd, data: lsu_fmt};

    wb_lsu_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_lsu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lsu_valid),
        .din   (lsu_entry),
        .pop   (lsu_pop),
        .dout  (lsu_head),
        .count (lsu_count),
        .full  (lsu_full),
        .empty (lsu_empty)
    );

    // A full buffer steals the slot from the ALU so loads cannot starve.
    assign drain_force  = (lsu_count == CW'(LSU_DEPTH));
    assign alu_ready    = ~drain_force;
    assign lsu_ready    = ~lsu_full;
    assign alu_fire     = alu_valid & ~drain_force;
    assign lsu_pop      = drain_force | (~alu_valid & ~lsu_empty);
    assign commit_valid = alu_fire | lsu_pop;
    assign commit       = alu_fire ? '{rd: alu_rd, data: alu_data} : lsu_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            commit_count  <= '0;
        end else begin
            RegWrite <= commit_valid && (commit.rd != '0);
            if (commit_valid && (commit.rd != '0)) begin
                WriteRegister <= commit.rd;
                WriteData     <= commit.data;
            end
            if (commit_valid) begin
                commit_count <= commit_count + 32'd1;
            end
        end
    end

    // Issue is applied after the commit clear so a same-index collision stays busy.
    always_comb begin
        busy_next = busy;
        if (commit_valid) begin
            busy_next[commit.rd] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];

endmodule

// File: tb/tb_rv32_writeback_unit.sv
// Scoreboard bench for rv32_writeback_unit: a behavioural model predicts each
// commit, queues expected writes and compares them as RegWrite pulses appear.
module tb_rv32_writeback_unit;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid, alu_valid, lsu_valid;
    logic [4:0]  issue_rd, alu_rd, lsu_rd, rs1_idx, rs2_idx;
    logic [31:0] alu_data, lsu_data;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_addr_lo;
    logic        alu_ready, lsu_ready, rs1_busy, rs2_busy, RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData, commit_count;

    ent_t        mq[$];
    ent_t        exp_q[$];
    int unsigned m_count;
    logic [31:0] m_busy;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    rv32_writeback_unit #(
        .XLEN      (32),
        .NREGS     (32),
        .LSU_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .lsu_funct3    (lsu_funct3),
        .lsu_addr_lo   (lsu_addr_lo),
        .rs1_idx       (rs1_idx),
        .rs2_idx       (rs2_idx),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .commit_count  (commit_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = d >> (8 * int'(a));
        h = d >> (16 * int'(a[1]));
        case (f3)
            3'd0:    return {{24{b[7]}}, b[7:0]};
            3'd1:    return {{16{h[15]}}, h[15:0]};
            3'd2:    return d;
            3'd4:    return {24'b0, b[7:0]};
            3'd5:    return {16'b0, h[15:0]};
            default: return 32'b0;
        endcase
    endfunction

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid   = 1'b0; alu_rd   = '0; alu_data = '0;
        lsu_valid   = 1'b0; lsu_rd   = '0; lsu_data = '0;
        lsu_funct3  = '0;   lsu_addr_lo = '0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        ent_t e;
        ent_t ld;
        logic cv;
        logic full;
        full = (mq.size() == 2);
        chk("alu_ready", alu_ready, !full);
        chk("lsu_ready", lsu_ready, !full);
        cv = 1'b0;
        e  = '0;
        if (full) begin
            e = mq.pop_front(); cv = 1'b1;
        end else if (alu_valid) begin
            e.rd = alu_rd; e.data = alu_data; cv = 1'b1;
        end else if (mq.size() != 0) begin
            e = mq.pop_front(); cv = 1'b1;
        end
        if (lsu_valid && !full) begin
            ld.rd   = lsu_rd;
            ld.data = ref_fmt(lsu_funct3, lsu_addr_lo, lsu_data);
            mq.push_back(ld);
        end
        if (cv) begin
            m_count++;
            m_busy[e.rd] = 1'b0;
            if (e.rd != 0) begin
                exp_q.push_back(e);
                m_wreg  = e.rd;
                m_wdata = e.data;
            end
        end
        if (issue_valid) m_busy[issue_rd] = 1'b1;
        m_busy[0] = 1'b0;
        @(negedge clk);
        chk("RegWrite", RegWrite, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("WriteRegister", WriteRegister, e.rd);
            chk("WriteData", WriteData, e.data);
        end else begin
            chk("WriteRegister_hold", WriteRegister, m_wreg);
            chk("WriteData_hold", WriteData, m_wdata);
        end
        chk("commit_count", commit_count, m_count);
        chk("rs1_busy", rs1_busy, m_busy[rs1_idx]);
        chk("rs2_busy", rs2_busy, m_busy[rs2_idx]);
    endtask

    // Asserts rst between edges, checks the asynchronous clear, releases at the next falling edge.
    task automatic do_reset();
        idle();
        #2 rst = 1'b1;
        #1;
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_WriteRegister", WriteRegister, 0);
        chk("rst_WriteData", WriteData, 0);
        chk("rst_commit_count", commit_count, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_lsu_ready", lsu_ready, 1);
        chk("rst_rs1_busy", rs1_busy, 0);
        chk("rst_rs2_busy", rs2_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
        m_count = 0; m_busy = '0; m_wreg = '0; m_wdata = '0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                        input logic [31:0] d);
        lsu_valid = 1'b1; lsu_rd = rd; lsu_funct3 = f3; lsu_addr_lo = a; lsu_data = d;
    endtask

    initial begin
        rs1_idx = '0; rs2_idx = '0;
        do_reset();

        // Basic ALU commit with a hazard on rs1
        rs1_idx = 5'd5; rs2_idx = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd5;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_commit_count", commit_count, 1);
        idle();
        step();

        // Load formatting
        load(5'd3, 3'b000, 2'd3, 32'h80123456); step();
        idle(); step();
        chk("lb_value", WriteData, 32'hFFFFFF80);
        load(5'd4, 3'b101, 2'd2, 32'hABCD1234); step();
        idle(); step();
        chk("lhu_value", WriteData, 32'h0000ABCD);
        load(5'd8, 3'b011, 2'd0, 32'hFFFFFFFF); step();
        idle(); step();
        chk("bad_f3_value", WriteData, 32'h00000000);
        load(5'd9, 3'b001, 2'd0, 32'h00018001); step();
        idle(); step();

        // Arbitration under pressure: full buffer forces a drain
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_00A0;
        load(5'd6, 3'b010, 2'd0, 32'h6666_0006); step();
        alu_rd = 5'd11; alu_data = 32'h0000_00A1;
        load(5'd7, 3'b010, 2'd0, 32'h7777_0007); step();
        alu_rd = 5'd12; alu_data = 32'h0000_00A2;
        load(5'd13, 3'b010, 2'd0, 32'hBAD0_BAD0); step();
        lsu_valid = 1'b0;
        step();
        alu_valid = 1'b0;
        step();
        idle(); step();

        // x0 handling
        rs1_idx = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        idle(); step();

        // Set/clear collision on x9
        rs1_idx = 5'd9; rs2_idx = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9; step();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0009; step();
        idle(); step();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0010; step();
        idle(); step();

        // Reset with one load buffered; nothing may be written afterwards
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h0000_0E0E;
        load(5'd15, 3'b010, 2'd0, 32'h0F0F_0F0F);
        issue_valid = 1'b1; issue_rd = 5'd15;
        rs1_idx = 5'd15;
        step();
        do_reset();
        for (int i = 0; i < 4; i++) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 31));
            alu_valid   = ($urandom_range(0, 2) != 0);
            alu_rd      = 5'($urandom_range(0, 31));
            alu_data    = $urandom;
            lsu_valid   = 1'($urandom_range(0, 1));
            lsu_rd      = 5'($urandom_range(0, 31));
            lsu_data    = $urandom;
            lsu_funct3  = 3'($urandom_range(0, 7));
            lsu_addr_lo = 2'($urandom_range(0, 3));
            rs1_idx     = 5'($urandom_range(0, 31));
            rs2_idx     = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32_writeback_unit.md
Name: rv32_writeback_unit

Overview:
- Writer side of the integer register file. Collects results from the ALU and from the load/store unit (LSU), and formats load data.
- Arbitrates one commit per cycle and drives RegWrite/WriteRegister/WriteData into the register file.
- Keeps a pending-write scoreboard that decode queries for rs1/rs2 hazards.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural register count (index width = 5)
LSU_DEPTH, 2, LSU result buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
issue_valid  input  1  decode issued an instruction that writes issue_rd
issue_rd  input  5  destination of issued instruction
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted when alu_valid&alu_ready
alu_rd  input  5  ALU destination
alu_data  input  XLEN  ALU result
lsu_valid  input  1  load result offered
lsu_ready  output  1  load result accepted when lsu_valid&lsu_ready
lsu_rd  input  5  load destination
lsu_data  input  XLEN  raw aligned memory word
lsu_funct3  input  3  load type
lsu_addr_lo  input  2  byte address bits [1:0]
rs1_idx  input  5  decode source 1
rs2_idx  input  5  decode source 2
rs1_busy  output  1  rs1 has an uncommitted write
rs2_busy  output  1  rs2 has an uncommitted write
RegWrite  output  1  register-file write enable
WriteRegister  output  5  register-file write index
WriteData  output  XLEN  register-file write data
commit_count  output  32  number of committed writes, including rd=0

Behaviour:
- Clocking and reset:
  - Single clock domain, clk rising edge.
  - rst is asynchronous and active-high; it clears RegWrite, WriteRegister, WriteData, commit_count, the busy vector and the LSU buffer (pointers and count) to 0.
  - While rst is high: alu_ready=1, lsu_ready=1, rs*_busy=0.
- Load formatting is combinational, applied before the buffer push:
  - 000 LB: byte lsu_addr_lo, sign-extended.
  - 001 LH: half lsu_addr_lo[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extended.
  - Any other funct3: result 0, entry still retires.
- LSU buffer:
  - FIFO of LSU_DEPTH entries {rd, formatted data}.
  - lsu_ready = (count != LSU_DEPTH), computed from registered count only. When full, no push is accepted even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Arbitration, one commit per cycle:
  - If count == LSU_DEPTH, the FIFO head commits and alu_ready=0.
  - Otherwise alu_ready=1. The ALU commits if alu_valid, else the FIFO head commits if non-empty.
  - Loads cannot starve: a full buffer forces a drain.
- Commit output timing:
  - Outputs are registered. A committed result appears on RegWrite/WriteRegister/WriteData at the rising edge after its handshake (latency 1). The register file captures it at the following falling edge.
  - RegWrite is high for exactly one cycle per commit.
  - WriteRegister and WriteData hold their last value while RegWrite=0.
- rd = 0:
  - The handshake and pop proceed normally and commit_count increments.
  - RegWrite stays 0 and WriteRegister/WriteData are not updated.
- Scoreboard:
  - 32-bit busy vector; bit 0 is hard-wired to 0.
  - issue_valid with issue_rd != 0 sets busy[issue_rd] at the next edge.
  - A commit clears busy[rd] at the same edge that RegWrite is registered.
  - If set and clear hit the same index in one cycle, set wins.
  - rs1_busy = busy[rs1_idx], rs2_busy = busy[rs2_idx], both combinational.
- commit_count increments by 1 per commit and wraps at 2^32.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). Buffered loads are discarded. No partial write is emitted.

Decomposition:
- Package rv32_wb_pkg:
  - XLEN and REG_IDX_W constants.
  - Load funct3 localparams: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Typedef wb_entry_t {rd, data}.
- One sub-module, wb_lsu_fifo: parameterised LSU_DEPTH buffer with count, full and empty, asynchronous reset.
- Load formatting and arbitration stay in the top module.

Test Plan:
1. Reset: pulse rst asynchronously between edges -> RegWrite=0, WriteRegister=0, WriteData=0, commit_count=0, alu_ready=1, lsu_ready=1, rs1_busy=0.
2. Basic ALU commit: issue_rd=5 one cycle, then alu_valid with rd=5, data=0xDEADBEEF.
   -> With rs1_idx=5: rs1_busy=1 until the commit edge.
   -> At the next edge: RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF for one cycle; rs1_busy=0; commit_count=1.
3. Load formatting:
   -> LB, addr_lo=3, data=0x80123456 -> WriteData=0xFFFFFF80.
   -> LHU, addr_lo=2, data=0xABCD1234 -> WriteData=0x0000ABCD.
   -> funct3=011 -> WriteData=0x00000000.
4. Arbitration under pressure: ALU valid every cycle; push loads rd=6, then rd=7.
   -> Count reaches 2, so lsu_ready=0 and alu_ready=0.
   -> Commit order from there: rd6, then one ALU result, then rd7.
5. x0 handling: alu rd=0, data=0x1234 -> handshake completes, RegWrite stays 0, commit_count increments. issue_rd=0 -> busy[0] stays 0.
6. Collisions and reset mid-operation:
   -> busy[9]=1, commit of rd=9 coincides with issue_rd=9 -> busy[9] remains 1.
   -> Assert rst with one load buffered -> buffer empty, RegWrite=0, and no write emitted after rst is released.
